// File: rtl/rom_loader_pkg.sv
// rom_loader_pkg
// Shared definitions for the ROM download sequencer.
//   state_t      : sequencer states (IDLE, ARM, WR, DONE)
//   PAGE_*       : fixed 9-bit ROM pages {rom_sel, page[7:0]}
//   is_hex_char  : true for ASCII '0'-'9' or 'A'-'F'
//   hex_char_val : nibble value of an ASCII hex character
package rom_loader_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        ARM  = 2'd1,
        WR   = 2'd2,
        DONE = 2'd3
    } state_t;

    localparam logic [8:0] PAGE_OS     = 9'h000;
    localparam logic [8:0] PAGE_BASIC  = 9'h100;
    localparam logic [8:0] PAGE_AMSDOS = 9'h107;
    localparam logic [8:0] PAGE_MF2    = 9'h1FF;
    localparam logic [8:0] PAGE_BADEXT = 9'h1EE;

    function automatic logic is_hex_char(input logic [7:0] c);
        return ((c >= 8'h30) && (c <= 8'h39)) || ((c >= 8'h41) && (c <= 8'h46));
    endfunction

    // Digits carry their value in the low nibble; 'A'..'F' have low nibble
    // 1..6, so adding 9 lands on 10..15.
    function automatic logic [3:0] hex_char_val(input logic [7:0] c);
        logic [3:0] v;
        if (c <= 8'h39) begin
            v = c[3:0];
        end else begin
            v = c[3:0] + 4'd9;
        end
        return v;
    endfunction

endpackage

// File: rtl/rom_ext_decode.sv
// rom_ext_decode
// Turns the last two characters of an expansion ROM file extension into the
// starting page and the combo flag.
//   file_ext : input, 16 bits, {high char, low char} in ASCII
//   page     : output, 9 bits, {rom_sel, page[7:0]}
//   combo    : output, 1 bit, set for "Z0" (two-part image, second half at MF2)
module rom_ext_decode
    import rom_loader_pkg::*;
(
    input  logic [15:0] file_ext,
    output logic [8:0]  page,
    output logic        combo
);

    always_comb begin
        page  = PAGE_BADEXT;
        combo = 1'b0;
        if (file_ext == 16'h5A5A) begin
            // "ZZ"
            page = 9'h000;
        end else if (file_ext == 16'h5A30) begin
            // "Z0"
            page  = 9'h000;
            combo = 1'b1;
        end else begin
            if (is_hex_char(file_ext[15:8])) begin
                page[7:4] = hex_char_val(file_ext[15:8]);
            end
            if (is_hex_char(file_ext[7:0])) begin
                page[3:0] = hex_char_val(file_ext[7:0]);
            end
        end
    end

endmodule

// File: rtl/rom_loader.sv
// rom_loader
// Sequences HPS download bytes into SDRAM write slots aligned to ce_ref, holds
// the HPS off with ioctl_wait and keeps the 256-entry upper-ROM presence map.
//   clk_sys, reset_n        : clock, async active-low reset (also clears map)
//   ce_ref                  : SDRAM slot strobe, one pulse per 16 clocks
//   ioctl_download/wr/addr/dout/index/file_ext : HPS download interface
//   ioctl_wait              : hold-off to the HPS while a byte is in flight
//   mem_we/addr/bank/din    : SDRAM write request, {rom_sel,page,offset}
//   map_rd_addr/map_rd_data : registered presence-map lookup
//   busy                    : sequencer not idle
module rom_loader
    import rom_loader_pkg::*;
(
    input  logic        clk_sys,
    input  logic        reset_n,
    input  logic        ce_ref,
    input  logic        ioctl_download,
    input  logic        ioctl_wr,
    input  logic [24:0] ioctl_addr,
    input  logic [7:0]  ioctl_dout,
    input  logic [7:0]  ioctl_index,
    input  logic [15:0] ioctl_file_ext,
    output logic        ioctl_wait,
    output logic        mem_we,
    output logic [22:0] mem_addr,
    output logic [1:0]  mem_bank,
    output logic [7:0]  mem_din,
    input  logic [7:0]  map_rd_addr,
    output logic        map_rd_data,
    output logic        busy
);

    state_t       state_q, state_d;
    logic [8:0]   page_q, page_d;
    logic         combo_q, combo_d;
    logic         download_q, download_d;
    logic         wait_q, wait_d;
    logic         we_q, we_d;
    logic [22:0]  addr_q, addr_d;
    logic [1:0]   bank_q, bank_d;
    logic [7:0]   din_q, din_d;
    logic         dup_q, dup_d;
    logic [255:0] map_q, map_d;
    logic         map_rd_q, map_rd_d;

    logic [8:0]   ext_page;
    logic         ext_combo;

    logic         is_boot;
    logic [10:0]  boot_blk;
    logic         boot_ok;
    logic [8:0]   boot_page;
    logic [7:0]   exp_page;
    logic [22:0]  wr_addr;
    logic [1:0]   wr_bank;
    logic         wr_dup;
    logic         accept;
    logic         dl_rise;

    rom_ext_decode u_ext_decode (
        .file_ext (ioctl_file_ext),
        .page     (ext_page),
        .combo    (ext_combo)
    );

    // Address/bank of the byte on the HPS bus, ahead of acceptance.
    always_comb begin
        is_boot  = (ioctl_index == 8'd0);
        boot_blk = ioctl_addr[24:14];
        boot_ok  = (boot_blk[10:3] == 8'd0);
        case (boot_blk[1:0])
            2'd0:    boot_page = PAGE_OS;
            2'd1:    boot_page = PAGE_BASIC;
            2'd2:    boot_page = PAGE_AMSDOS;
            default: boot_page = PAGE_MF2;
        endcase
        exp_page = page_q[7:0] + ioctl_addr[21:14];
        if (is_boot) begin
            wr_addr = {boot_page, ioctl_addr[13:0]};
            wr_bank = {1'b0, boot_blk[2]};
        end else begin
            wr_addr = {page_q[8], exp_page, ioctl_addr[13:0]};
            wr_bank = {1'b0, &ioctl_index[7:6]};
        end
        wr_dup  = (ioctl_index[7:6] == 2'b01) || (ioctl_index[5:0] != 6'd0);
        accept  = ioctl_wr && (!is_boot || boot_ok);
        dl_rise = ioctl_download && !download_q;
    end

    // Sequencer next state. A download rising edge re-latches the page even
    // mid-byte; the in-flight byte already holds its own address, and the
    // re-latch wins over the combo switch-over if both land together.
    always_comb begin
        state_d    = state_q;
        page_d     = page_q;
        combo_d    = combo_q;
        download_d = ioctl_download;
        wait_d     = wait_q;
        we_d       = we_q;
        addr_d     = addr_q;
        bank_d     = bank_q;
        din_d      = din_q;
        dup_d      = dup_q;
        map_d      = map_q;
        map_rd_d   = map_q[map_rd_addr];

        case (state_q)
            IDLE: begin
                if (accept) begin
                    addr_d  = wr_addr;
                    bank_d  = wr_bank;
                    din_d   = ioctl_dout;
                    dup_d   = wr_dup;
                    wait_d  = 1'b1;
                    state_d = ARM;
                end
            end
            ARM: begin
                if (ce_ref) begin
                    we_d    = 1'b1;
                    state_d = WR;
                end
            end
            WR: begin
                if (ce_ref) begin
                    we_d = 1'b0;
                    if (dup_q && (bank_q == 2'd0)) begin
                        bank_d  = 2'd1;
                        state_d = ARM;
                    end else begin
                        wait_d  = 1'b0;
                        state_d = DONE;
                    end
                end
            end
            default: begin
                if (addr_q[22]) begin
                    map_d[addr_q[21:14]] = 1'b1;
                end
                // Two-part image: once the first 16 KB is in, the rest
                // continues at the MF2 page (wrapping to upper page 0).
                if (combo_q && (addr_q[13:0] == 14'h3FFF)) begin
                    combo_d = 1'b0;
                    page_d  = PAGE_MF2;
                end
                state_d = IDLE;
            end
        endcase

        if (dl_rise && !is_boot) begin
            page_d  = ext_page;
            combo_d = ext_combo;
        end
    end

    always_ff @(posedge clk_sys or negedge reset_n) begin
        if (!reset_n) begin
            state_q    <= IDLE;
            page_q     <= 9'h000;
            combo_q    <= 1'b0;
            download_q <= 1'b0;
            wait_q     <= 1'b0;
            we_q       <= 1'b0;
            addr_q     <= 23'd0;
            bank_q     <= 2'd0;
            din_q      <= 8'd0;
            dup_q      <= 1'b0;
            map_q      <= '0;
            map_rd_q   <= 1'b0;
        end else begin
            state_q    <= state_d;
            page_q     <= page_d;
            combo_q    <= combo_d;
            download_q <= download_d;
            wait_q     <= wait_d;
            we_q       <= we_d;
            addr_q     <= addr_d;
            bank_q     <= bank_d;
            din_q      <= din_d;
            dup_q      <= dup_d;
            map_q      <= map_d;
            map_rd_q   <= map_rd_d;
        end
    end

    assign ioctl_wait  = wait_q;
    assign mem_we      = we_q;
    assign mem_addr    = addr_q;
    assign mem_bank    = bank_q;
    assign mem_din     = din_q;
    assign map_rd_data = map_rd_q;
    assign busy        = (state_q != IDLE);

endmodule
